// File: rtl/seg_pkg.sv
// Shared segment types, glyph constants and the nibble-to-segment decoder.
package seg_pkg;

  // Segment pattern {a,b,c,d,e,f,g,dp}, active-low.
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0    = 8'b0000_0011;
  localparam seg_t SEG_1    = 8'b1001_1111;
  localparam seg_t SEG_2    = 8'b0010_0101;
  localparam seg_t SEG_3    = 8'b0000_1101;
  localparam seg_t SEG_4    = 8'b1001_1001;
  localparam seg_t SEG_5    = 8'b0100_1001;
  localparam seg_t SEG_6    = 8'b0100_0001;
  localparam seg_t SEG_7    = 8'b0001_1111;
  localparam seg_t SEG_8    = 8'b0000_0001;
  localparam seg_t SEG_9    = 8'b0000_1001;
  localparam seg_t SEG_A    = 8'b0001_0001;
  localparam seg_t SEG_B    = 8'b1100_0001;
  localparam seg_t SEG_C    = 8'b0110_0011;
  localparam seg_t SEG_D    = 8'b1000_0101;
  localparam seg_t SEG_E    = 8'b0110_0001;
  localparam seg_t SEG_F    = 8'b0111_0001;
  localparam seg_t SEG_DASH = 8'b1111_1101;
  localparam seg_t SEG_OFF  = 8'hFF;

  // Decode one nibble; codes above 9 become a dash when hex is disabled.
  function automatic seg_t seg_decode(input logic [3:0] nib, input logic hex_en);
    seg_t s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    if (!hex_en && (nib > 4'd9)) s = SEG_DASH;
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index counter for the scanned display.
module seg_scan_timer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned GUARD_CYC  = 500,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             in_guard,
  output logic             frame_wrap
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             cnt_max;
  logic             idx_max;

  assign cnt_max    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_max    = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = cnt_max && idx_max;

  // Guard window at the start of every slot; absent when GUARD_CYC is zero.
  generate
    if (GUARD_CYC == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt < CNT_W'(GUARD_CYC));
    end
  endgenerate

  // Count cycles within a slot and advance the digit at each slot end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_max) begin
      cnt <= '0;
      idx <= idx_max ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-latched data.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned GUARD_CYC  = 500,
  parameter int unsigned HEX_EN     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_lzs,
  output logic [NUM_DIGITS-1:0]   o_sel_bcd,
  output logic [7:0]              o_display,
  output logic                    o_frame_tick
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IDX_W-1:0]      idx;
  logic                  in_guard;
  logic                  frame_wrap;

  logic [3:0]            sh_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_blank;
  logic                  sh_lzs;

  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] sel_nxt;
  seg_t                  disp_nxt;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .GUARD_CYC  (GUARD_CYC)
  ) u_timer (
    .clk        (i_clk),
    .rst        (i_rst),
    .idx        (idx),
    .in_guard   (in_guard),
    .frame_wrap (frame_wrap)
  );

  // Latch a whole frame of inputs at the last cycle of the last slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) sh_digit[k] <= 4'd0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lzs   <= 1'b0;
    end else if (frame_wrap) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) sh_digit[k] <= i_data[4*k +: 4];
      sh_dp    <= i_dp;
      sh_blank <= i_blank;
      sh_lzs   <= i_lzs;
    end
  end

  // A digit is suppressed when it and every digit to its left are zero (never digit 0).
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run = zero_run && (sh_digit[k] == 4'd0);
      if (k > 0) supp[k] = sh_lzs && zero_run;
    end
  end

  // Next select/segment pattern for the current slot position.
  always_comb begin
    sel_nxt  = '1;
    disp_nxt = SEG_OFF;
    if (!in_guard) begin
      sel_nxt[idx] = 1'b0;
      if (!sh_blank[idx]) begin
        if (!supp[idx]) disp_nxt = seg_decode(sh_digit[idx], HEX_EN != 0);
        if (sh_dp[idx]) disp_nxt[0] = 1'b0;
      end
    end
  end

  // Register all outputs; the frame tick follows the capture cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sel_bcd    <= '1;
      o_display    <= SEG_OFF;
      o_frame_tick <= 1'b0;
    end else begin
      o_sel_bcd    <= sel_nxt;
      o_display    <= disp_nxt;
      o_frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display (4 digits, 8-cycle slots, 2-cycle guard).
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lzs;

  logic [3:0]  sel_h1, sel_h0;
  logic [7:0]  disp_h1, disp_h0;
  logic        tick_h1, tick_h0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_d [4];
  logic        use_h0 = 1'b0;

  always #5 clk = ~clk;

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD_CYC(2), .HEX_EN(1)) u_dut_hex (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_blank(blank), .i_lzs(lzs),
    .o_sel_bcd(sel_h1), .o_display(disp_h1), .o_frame_tick(tick_h1)
  );

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD_CYC(2), .HEX_EN(0)) u_dut_dec (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_blank(blank), .i_lzs(lzs),
    .o_sel_bcd(sel_h0), .o_display(disp_h0), .o_frame_tick(tick_h0)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs;
    logic        hex0;
    logic [31:0] exp;   // {digit3, digit2, digit1, digit0} segment patterns
  } vec_t;

  vec_t vecs [10];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic set_exp(input logic [31:0] e);
    for (int k = 0; k < 4; k++) exp_d[k] = e[8*k +: 8];
  endtask

  // Frame offset j counts cycles after a tick cycle (j=0); j=32 is the next tick.
  task automatic check_cycles(input string tag, input int from, input int to);
    int         slot, pos;
    logic [3:0] es;
    logic [7:0] ed;
    logic [3:0] as;
    logic [7:0] ad;
    logic       at;
    for (int j = from; j <= to; j++) begin
      @(negedge clk);
      slot = (j - 1) / 8;
      pos  = (j - 1) % 8;
      es   = 4'hF;
      ed   = 8'hFF;
      if (pos >= 2) begin
        es[slot] = 1'b0;
        ed       = exp_d[slot];
      end
      as = use_h0 ? sel_h0  : sel_h1;
      ad = use_h0 ? disp_h0 : disp_h1;
      at = use_h0 ? tick_h0 : tick_h1;
      check8($sformatf("%s j%0d sel", tag, j), {4'h0, as}, {4'h0, es});
      check8($sformatf("%s j%0d disp", tag, j), ad, ed);
      check8($sformatf("%s j%0d tick", tag, j), {7'h0, at}, {7'h0, (j == 32)});
    end
  endtask

  task automatic wait_tick(input string tag);
    logic seen;
    logic t;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      t = use_h0 ? tick_h0 : tick_h1;
      if (t) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s tick timeout: got no tick in 100 cycles, expected one", tag);
    end
  endtask

  task automatic check_reset(input string tag);
    check8({tag, " sel_hex"},  {4'h0, sel_h1}, 8'h0F);
    check8({tag, " disp_hex"}, disp_h1,        8'hFF);
    check8({tag, " tick_hex"}, {7'h0, tick_h1}, 8'h00);
    check8({tag, " sel_dec"},  {4'h0, sel_h0}, 8'h0F);
    check8({tag, " disp_dec"}, disp_h0,        8'hFF);
    check8({tag, " tick_dec"}, {7'h0, tick_h0}, 8'h00);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
    vecs[1] = '{16'hABCD, 4'b0100, 4'b0000, 1'b0, 1'b0, {8'h11, 8'hC0, 8'h63, 8'h85}};
    vecs[2] = '{16'hABCD, 4'b0100, 4'b0000, 1'b0, 1'b1, {8'hFD, 8'hFC, 8'hFD, 8'hFD}};
    vecs[3] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b0, {8'hFF, 8'hFF, 8'h49, 8'h03}};
    vecs[4] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[5] = '{16'h0000, 4'b0000, 4'b0001, 1'b0, 1'b0, {8'h03, 8'h03, 8'h03, 8'hFF}};
    vecs[6] = '{16'h1234, 4'b1111, 4'b0000, 1'b1, 1'b0, {8'h9E, 8'h24, 8'h0C, 8'h98}};
    vecs[7] = '{16'h0007, 4'b1000, 4'b0000, 1'b1, 1'b0, {8'hFE, 8'hFF, 8'hFF, 8'h1F}};
    vecs[8] = '{16'h0E8F, 4'b0000, 4'b0000, 1'b0, 1'b0, {8'h03, 8'h61, 8'h01, 8'h71}};
    vecs[9] = '{16'h6590, 4'b0000, 4'b0000, 1'b0, 1'b1, {8'h41, 8'h49, 8'h09, 8'h03}};

    rst   = 1'b1;
    data  = 16'h0;
    dp    = 4'h0;
    blank = 4'h0;
    lzs   = 1'b0;

    // Reset state, then the first frame from zeroed shadow registers.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    set_exp({8'h03, 8'h03, 8'h03, 8'h03});
    check_cycles("after_reset", 1, 32);

    // Table of full frames.
    for (int v = 0; v < 10; v++) begin
      data   = vecs[v].data;
      dp     = vecs[v].dp;
      blank  = vecs[v].blank;
      lzs    = vecs[v].lzs;
      use_h0 = vecs[v].hex0;
      wait_tick($sformatf("vec%0d", v));
      set_exp(vecs[v].exp);
      check_cycles($sformatf("vec%0d", v), 1, 32);
    end

    // Mid-frame input change must not reach the outputs before the next capture.
    use_h0 = 1'b0;
    data   = 16'h1234;
    dp     = 4'h0;
    blank  = 4'h0;
    lzs    = 1'b0;
    wait_tick("tear");
    set_exp({8'h9F, 8'h25, 8'h0D, 8'h99});
    check_cycles("tear_old", 1, 10);
    data = 16'h8888;
    dp   = 4'hF;
    check_cycles("tear_old", 11, 32);
    set_exp({8'h00, 8'h00, 8'h00, 8'h00});
    check_cycles("tear_new", 1, 32);

    // One-cycle reset in the middle of a slot restarts the scan at digit 0.
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    rst = 1'b0;
    set_exp({8'h03, 8'h03, 8'h03, 8'h03});
    check_cycles("midreset", 1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
